alu_seg_disp: RTL and testbench

- Parametrised successor to the 4-bit ALU/two-digit display block.
- Takes a start pulse and captures WIDTH-bit operands, an opcode and a display mode.
- Computes a registered ALU result and flags, then converts the result into DIGITS active-low seven-segment glyphs. Conversion is hex, unsigned decimal, or signed decimal; decimal uses an iterative double-dabble converter.
- Sits between board switches/buttons and the seven-segment outputs, with a start/busy/done handshake.

---
 rtl/alu_seg_disp.sv | 321 ++++++++++++++++++++++++++++++++
 tb/tb_alu_seg_disp.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seg_disp.sv
// Purpose : start-triggered ALU whose registered result is shown on DIGITS seven-segment digits.
// Latency : done pulses 3 edges after the start-sampling edge in hex, WIDTH+2 edges in decimal.
// Backpressure: none; start is only sampled while idle, busy covers the whole operation.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   start               request, sampled only while idle
//   opa, opb [WIDTH]    operands, captured together with code/mode on an accepted start
//   code [3]            ALU opcode (add, sub, and, or, xor, not-a, signed less-than, equal)
//   mode [2]            display mode: 00 hex, 01 unsigned decimal, 10 signed decimal, 11 hex
//   en                  display enable, gates seg only
//   busy, done          operation in progress / one-cycle completion pulse
//   zero, carry, ovf    flags of the last completed operation
//   seg [8*DIGITS]      active-low glyphs, digit i on seg[8i+7:8i], bit7=a .. bit1=g, bit0=dp

module alu_seg_disp #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      opa,
   input  logic [WIDTH-1:0]      opb,
   input  logic [2:0]            code,
   input  logic [1:0]            mode,
   input  logic                  en,
   output logic                  busy,
   output logic                  done,
   output logic                  zero,
   output logic                  carry,
   output logic                  ovf,
   output logic [8*DIGITS-1:0]   seg
);

   // Number of decimal digits needed for the largest unsigned WIDTH-bit value.
   function automatic int f_dec_digits(input int w);
      int v;
      int n;
      v = (1 << w) - 1;
      n = 0;
      for (int k = 0; k < 10; k++) begin
         if (v > 0) begin
            n = n + 1;
            v = v / 10;
         end
      end
      return n;
   endfunction

   localparam int DEC_DIGITS = f_dec_digits(WIDTH);
   localparam int CW         = $clog2(WIDTH);
   localparam int BW         = 4 * DIGITS;

   generate
      if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
         $error("alu_seg_disp: WIDTH must lie in 4..16");
      end
      if (DIGITS < DEC_DIGITS + 1 || BW < WIDTH) begin : g_bad_digits
         $error("alu_seg_disp: DIGITS too small for WIDTH (sign digit plus magnitude, or hex)");
      end
   endgenerate

   // Active-low glyphs, bit order a..g then dp (dp always off).
   function automatic logic [7:0] f_glyph(input logic [3:0] d);
      logic [7:0] g;
      case (d)
         4'h0:    g = 8'h03;
         4'h1:    g = 8'h9F;
         4'h2:    g = 8'h25;
         4'h3:    g = 8'h0D;
         4'h4:    g = 8'h99;
         4'h5:    g = 8'h49;
         4'h6:    g = 8'h41;
         4'h7:    g = 8'h1F;
         4'h8:    g = 8'h01;
         4'h9:    g = 8'h09;
         4'hA:    g = 8'h11;
         4'hB:    g = 8'hC1;
         4'hC:    g = 8'h63;
         4'hD:    g = 8'h85;
         4'hE:    g = 8'h61;
         default: g = 8'h71;
      endcase
      return g;
   endfunction

   // Double-dabble correction: any BCD digit of 5 or more gets +3 before the shift.
   function automatic logic [BW-1:0] f_add3(input logic [BW-1:0] b);
      logic [BW-1:0] r;
      r = b;
      for (int i = 0; i < DIGITS; i++) begin
         if (r[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

   localparam logic [7:0] GLYPH_BLANK = 8'hFF;
   localparam logic [7:0] GLYPH_MINUS = 8'hFD;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_CONV,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   // Captured request
   logic [WIDTH-1:0]  r_opa;
   logic [WIDTH-1:0]  r_opb;
   logic [2:0]        r_code;
   logic [1:0]        r_mode;

   // ALU stage
   logic [WIDTH:0]    w_sum;
   logic [WIDTH:0]    w_diff;
   logic [WIDTH-1:0]  w_res;
   logic              w_alu_carry;
   logic              w_alu_ovf;
   logic [WIDTH-1:0]  r_res;
   logic              r_alu_carry;
   logic              r_alu_ovf;
   logic              r_neg;

   // Conversion stage
   logic [WIDTH-1:0]  r_bin;
   logic [BW-1:0]     r_bcd;
   logic [BW-1:0]     w_bcd_adj;
   logic [CW-1:0]     r_cnt;
   logic              w_dec;
   logic              w_conv_last;

   // Display build
   logic [8*DIGITS-1:0] w_seg_nxt;
   logic [BW-1:0]       w_hex_v;
   logic                w_lead;
   logic [3:0]          w_nib;

   // Output registers
   logic                r_done;
   logic                r_zero;
   logic                r_carry;
   logic                r_ovf;
   logic                r_valid;
   logic [8*DIGITS-1:0] r_seg;

   assign w_dec       = (r_mode == 2'b01) || (r_mode == 2'b10);
   assign w_conv_last = !w_dec || (r_cnt == CW'(WIDTH - 1));

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_CALC;
         S_CALC:  w_state_nxt = S_CONV;
         S_CONV:  if (w_conv_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // ALU on the captured operands
   // ------------------------------------------------------------------
   assign w_sum  = {1'b0, r_opa} + {1'b0, r_opb};
   assign w_diff = {1'b0, r_opa} - {1'b0, r_opb};

   always_comb begin
      w_res       = '0;
      w_alu_carry = 1'b0;
      w_alu_ovf   = 1'b0;
      case (r_code)
         3'b000: begin
            w_res       = w_sum[WIDTH-1:0];
            w_alu_carry = w_sum[WIDTH];
            // Same-sign operands producing a different-sign sum
            w_alu_ovf   = (r_opa[WIDTH-1] == r_opb[WIDTH-1]) &&
                          (w_sum[WIDTH-1] != r_opa[WIDTH-1]);
         end
         3'b001: begin
            w_res       = w_diff[WIDTH-1:0];
            // The extra bit of the zero-extended difference is the borrow (a < b)
            w_alu_carry = w_diff[WIDTH];
            w_alu_ovf   = (r_opa[WIDTH-1] != r_opb[WIDTH-1]) &&
                          (w_diff[WIDTH-1] != r_opa[WIDTH-1]);
         end
         3'b010: w_res = r_opa & r_opb;
         3'b011: w_res = r_opa | r_opb;
         3'b100: w_res = r_opa ^ r_opb;
         3'b101: w_res = ~r_opa;
         3'b110: w_res[0] = ($signed(r_opa) < $signed(r_opb));
         3'b111: w_res[0] = (r_opa == r_opb);
         default: w_res = '0;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath registers: capture, ALU result, double-dabble shifter
   // ------------------------------------------------------------------
   assign w_bcd_adj = f_add3(r_bcd);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_opa       <= '0;
         r_opb       <= '0;
         r_code      <= '0;
         r_mode      <= '0;
         r_res       <= '0;
         r_alu_carry <= 1'b0;
         r_alu_ovf   <= 1'b0;
         r_neg       <= 1'b0;
         r_bin       <= '0;
         r_bcd       <= '0;
         r_cnt       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_opa  <= opa;
                  r_opb  <= opb;
                  r_code <= code;
                  r_mode <= mode;
               end
            end
            S_CALC: begin
               r_res       <= w_res;
               r_alu_carry <= w_alu_carry;
               r_alu_ovf   <= w_alu_ovf;
               // Negation is taken modulo 2^WIDTH, so the most negative value
               // yields its correct unsigned magnitude (e.g. 0x80 -> 128).
               r_neg       <= (r_mode == 2'b10) && w_res[WIDTH-1];
               r_bin       <= ((r_mode == 2'b10) && w_res[WIDTH-1]) ? -w_res : w_res;
               r_bcd       <= '0;
               r_cnt       <= '0;
            end
            S_CONV: begin
               if (w_dec) begin
                  {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
                  r_cnt          <= r_cnt + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Glyph assembly, consumed on the DONE edge
   // ------------------------------------------------------------------
   always_comb begin
      w_seg_nxt = '1;
      w_hex_v   = '0;
      w_hex_v[WIDTH-1:0] = r_res;
      w_lead    = 1'b1;
      w_nib     = '0;
      // Scan from the most significant digit; stay blank until the first
      // non-zero BCD digit, but digit 0 always shows.
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (w_dec) begin
            w_nib = r_bcd[4*i +: 4];
            if (w_nib != 4'd0 || i == 0) begin
               w_lead = 1'b0;
            end
            w_seg_nxt[8*i +: 8] = w_lead ? GLYPH_BLANK : f_glyph(w_nib);
         end else begin
            w_seg_nxt[8*i +: 8] = f_glyph(w_hex_v[4*i +: 4]);
         end
      end
      // Top digit is reserved for the sign; the magnitude never reaches it.
      if (r_mode == 2'b10) begin
         w_seg_nxt[8*DIGITS-1 -: 8] = r_neg ? GLYPH_MINUS : GLYPH_BLANK;
      end
   end

   // ------------------------------------------------------------------
   // Output registers: loaded only on the DONE edge, held otherwise
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done  <= 1'b0;
         r_zero  <= 1'b0;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
         r_valid <= 1'b0;
         r_seg   <= '1;
      end else begin
         r_done <= (r_state == S_DONE);
         if (r_state == S_DONE) begin
            r_zero  <= (r_res == '0);
            r_carry <= r_alu_carry;
            r_ovf   <= r_alu_ovf;
            r_valid <= 1'b1;
            r_seg   <= w_seg_nxt;
         end
      end
   end

   assign busy  = (r_state != S_IDLE);
   assign done  = r_done;
   assign zero  = r_zero;
   assign carry = r_carry;
   assign ovf   = r_ovf;
   assign seg   = (en && r_valid) ? r_seg : '1;

endmodule

// File: tb/tb_alu_seg_disp.sv
// Bench for alu_seg_disp (WIDTH=8, DIGITS=4): arithmetic reference model with
// per-cycle output comparison, plus directed vectors with literal expectations.
module tb_alu_seg_disp;

   localparam int WIDTH  = 8;
   localparam int DIGITS = 4;
   localparam int SW     = 8 * DIGITS;
   localparam int FULL   = 1 << WIDTH;
   localparam int HALF   = 1 << (WIDTH - 1);

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [WIDTH-1:0]  opa;
   logic [WIDTH-1:0]  opb;
   logic [2:0]        code;
   logic [1:0]        mode;
   logic              en;
   logic              busy;
   logic              done;
   logic              zero;
   logic              carry;
   logic              ovf;
   logic [SW-1:0]     seg;

   alu_seg_disp #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .opa   (opa),
      .opb   (opb),
      .code  (code),
      .mode  (mode),
      .en    (en),
      .busy  (busy),
      .done  (done),
      .zero  (zero),
      .carry (carry),
      .ovf   (ovf),
      .seg   (seg)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   bit chk_en  = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] glyph(input int d);
      case (d)
         0: return 8'h03;   1: return 8'h9F;   2: return 8'h25;   3: return 8'h0D;
         4: return 8'h99;   5: return 8'h49;   6: return 8'h41;   7: return 8'h1F;
         8: return 8'h01;   9: return 8'h09;  10: return 8'h11;  11: return 8'hC1;
        12: return 8'h63;  13: return 8'h85;  14: return 8'h61;
         default: return 8'h71;
      endcase
   endfunction

   task automatic alu_model(input int a, input int b, input logic [2:0] c,
                            output int res, output bit cy, output bit ov);
      int sa, sb, t;
      sa = (a >= HALF) ? a - FULL : a;
      sb = (b >= HALF) ? b - FULL : b;
      cy = 1'b0; ov = 1'b0; res = 0;
      case (c)
         3'd0: begin t = a + b; res = t % FULL; cy = (t >= FULL);
                     ov = (sa + sb > HALF - 1) || (sa + sb < -HALF); end
         3'd1: begin t = a - b; res = (t + FULL) % FULL; cy = (a < b);
                     ov = (sa - sb > HALF - 1) || (sa - sb < -HALF); end
         3'd2: res = a & b;
         3'd3: res = a | b;
         3'd4: res = a ^ b;
         3'd5: res = (FULL - 1) - a;
         3'd6: res = (sa < sb) ? 1 : 0;
         default: res = (a == b) ? 1 : 0;
      endcase
   endtask

   function automatic logic [SW-1:0] exp_seg(input int res, input logic [1:0] m);
      logic [SW-1:0] s;
      int v;
      bit neg;
      s = '1; v = res; neg = 1'b0;
      if (m == 2'b01 || m == 2'b10) begin
         if (m == 2'b10 && res >= HALF) begin neg = 1'b1; v = FULL - res; end
         for (int i = 0; i < DIGITS; i++) begin
            if (i == 0 || v > 0) s[8*i +: 8] = glyph(v % 10);
            v = v / 10;
         end
         if (m == 2'b10) s[SW-1 -: 8] = neg ? 8'hFD : 8'hFF;
      end else begin
         for (int i = 0; i < DIGITS; i++) s[8*i +: 8] = glyph((res >> (4*i)) & 15);
      end
      return s;
   endfunction

   logic          m_busy, m_done, m_zero, m_carry, m_ovf, m_valid;
   logic [SW-1:0] m_seg, p_seg, e_seg;
   logic          p_zero, p_cy, p_ov;
   int            m_left;
   int            t_res;
   bit            t_cy, t_ov;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_zero <= 1'b0; m_carry <= 1'b0;
         m_ovf <= 1'b0; m_valid <= 1'b0; m_seg <= '1; m_left <= 0;
      end else begin
         m_done <= 1'b0;
         if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_busy <= 1'b0; m_done <= 1'b1; m_valid <= 1'b1;
               m_zero <= p_zero; m_carry <= p_cy; m_ovf <= p_ov; m_seg <= p_seg;
            end
         end else if (start) begin
            alu_model(int'(opa), int'(opb), code, t_res, t_cy, t_ov);
            p_zero <= (t_res == 0);
            p_cy   <= t_cy;
            p_ov   <= t_ov;
            p_seg  <= exp_seg(t_res, mode);
            m_left <= (mode == 2'b01 || mode == 2'b10) ? WIDTH + 2 : 3;
            m_busy <= 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         e_seg = (en && m_valid) ? m_seg : {SW{1'b1}};
         check("cyc_busy",  busy,  m_busy);
         check("cyc_done",  done,  m_done);
         check("cyc_zero",  zero,  m_zero);
         check("cyc_carry", carry, m_carry);
         check("cyc_ovf",   ovf,   m_ovf);
         check("cyc_seg",   seg,   e_seg);
      end
   end

   // ---------------- directed stimulus ----------------
   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [2:0]  c;
      logic [1:0]  m;
      logic [31:0] s;
      int          lat;
      logic        z;
      logic        cy;
      logic        o;
   } vec_t;

   vec_t vecs [13];

   task automatic start_op(input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] c, input logic [1:0] m);
      opa = a; opb = b; code = c; mode = m; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Edges counted after the start-sampling edge until done is seen; -1 on timeout.
   task automatic wait_done(output int lat);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done) begin lat = k; break; end
      end
   endtask

   int lat;
   int n_done;

   initial begin
      vecs = '{
         '{8'hFF, 8'h01, 3'b000, 2'b00, 32'h03030303,  3, 1'b1, 1'b1, 1'b0},
         '{8'hC8, 8'h37, 3'b000, 2'b01, 32'hFF254949, 10, 1'b0, 1'b0, 1'b0},
         '{8'h03, 8'h08, 3'b001, 2'b10, 32'hFDFFFF49, 10, 1'b0, 1'b1, 1'b0},
         '{8'h80, 8'h01, 3'b001, 2'b10, 32'hFF9F251F, 10, 1'b0, 1'b0, 1'b1},
         '{8'h00, 8'h80, 3'b001, 2'b10, 32'hFD9F2501, 10, 1'b0, 1'b1, 1'b1},
         '{8'h80, 8'h01, 3'b110, 2'b00, 32'h0303039F,  3, 1'b0, 1'b0, 1'b0},
         '{8'h5A, 8'h5A, 3'b111, 2'b01, 32'hFFFFFF9F, 10, 1'b0, 1'b0, 1'b0},
         '{8'hA5, 8'h0F, 3'b010, 2'b11, 32'h03030349,  3, 1'b0, 1'b0, 1'b0},
         '{8'h3C, 8'h0F, 3'b100, 2'b01, 32'hFFFF499F, 10, 1'b0, 1'b0, 1'b0},
         '{8'h00, 8'h00, 3'b101, 2'b10, 32'hFDFFFF9F, 10, 1'b0, 1'b0, 1'b0},
         '{8'h00, 8'h00, 3'b000, 2'b01, 32'hFFFFFF03, 10, 1'b1, 1'b0, 1'b0},
         '{8'h7F, 8'h01, 3'b000, 2'b10, 32'hFD9F2501, 10, 1'b0, 1'b0, 1'b1},
         '{8'h7B, 8'h00, 3'b011, 2'b00, 32'h03031FC1,  3, 1'b0, 1'b0, 1'b0}
      };

      rst_n = 1'b0; start = 1'b0; en = 1'b1;
      opa = '0; opb = '0; code = '0; mode = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      check("rst_busy",  busy,  1'b0);
      check("rst_done",  done,  1'b0);
      check("rst_zero",  zero,  1'b0);
      check("rst_carry", carry, 1'b0);
      check("rst_ovf",   ovf,   1'b0);
      check("rst_seg",   seg,   32'hFFFFFFFF);

      foreach (vecs[i]) begin
         start_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].m);
         wait_done(lat);
         check($sformatf("v%0d_lat", i),   lat,   vecs[i].lat);
         check($sformatf("v%0d_seg", i),   seg,   vecs[i].s);
         check($sformatf("v%0d_zero", i),  zero,  vecs[i].z);
         check($sformatf("v%0d_carry", i), carry, vecs[i].cy);
         check($sformatf("v%0d_ovf", i),   ovf,   vecs[i].o);
      end

      // Start pulsed again and opa changed while busy: the original op completes once.
      start_op(8'h12, 8'h34, 3'b000, 2'b00);
      opa = 8'h77; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(lat);
      check("busy_lat", lat, 2);
      check("busy_seg", seg, 32'h03039941);
      n_done = 0;
      repeat (12) begin @(posedge clk); #1; if (done) n_done++; end
      check("busy_single_done", n_done, 0);

      // Reset in the middle of a decimal conversion.
      start_op(8'hC8, 8'h37, 3'b000, 2'b01);
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_seg",  seg,  32'hFFFFFFFF);
      @(posedge clk); #1 rst_n = 1'b1;
      n_done = 0;
      repeat (14) begin @(posedge clk); #1; if (done) n_done++; end
      check("abort_no_done", n_done, 0);
      check("abort_seg_hold", seg, 32'hFFFFFFFF);

      start_op(8'h64, 8'h0A, 3'b000, 2'b01);
      wait_done(lat);
      check("post_rst_lat", lat, 10);
      check("post_rst_seg", seg, 32'hFF9F9F03);

      // Display disabled: done still pulses, seg blank; re-enable shows the result.
      en = 1'b0;
      start_op(8'h0F, 8'hF0, 3'b100, 2'b00);
      wait_done(lat);
      check("en0_lat",  lat,  3);
      check("en0_done", done, 1'b1);
      check("en0_seg",  seg,  32'hFFFFFFFF);
      @(posedge clk); #1 en = 1'b1;
      #1;
      check("en1_seg", seg, 32'h03037171);

      repeat (3) @(posedge clk);
      #1 chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
